// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// It runs MULTU/MULT/DIVU/DIV over DATA_WIDTH iterations, then spends one
// cycle on sign correction. HI/LO change only on that correction edge, on an
// MTHI/MTLO write taken in IDLE, or at reset.
//
// Ports
//   CLK        clock, rising edge
//   rst        asynchronous active-low reset
//   Start      launch request, sampled only in IDLE
//   Op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with Start)
//   SrcA/SrcB  multiplicand/dividend and multiplier/divisor
//   HiWEn/LoWEn/WD  MTHI/MTLO writes, honoured only in IDLE
//   Busy       registered, high while state is RUN or FIX
//   Done       registered one-cycle pulse in the cycle after FIX
//   HI/LO      architectural registers
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 FIX) for observation
//
// Handshake: Start is a request that is accepted on any rising edge where the
// unit is IDLE; Busy is the "not ready" indication. A request made while Busy
// is dropped, not queued. Done marks the single cycle in which HI/LO first
// show the new result; Start may be asserted in that same cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  HiWEn,
  input  logic                  LoWEn,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic [1:0]            dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [1:0]    op_q;      // bit0 = signed, bit1 = divide
  logic          a_neg, b_neg;
  logic [W-1:0]  a_abs, b_abs;
  // acc_hi: product upper half (multiply) or partial remainder (divide).
  // acc_lo: multiplier being shifted out (multiply) or dividend shifting out
  // while quotient bits shift in (divide).
  logic [W-1:0]  acc_hi, acc_lo;

  // control strobes from the output process
  logic launch, last_iter, busy_nxt, done_nxt;

  // datapath helpers
  logic [W-1:0]  srca_abs, srcb_abs;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic          div_ge;
  logic [W-1:0]  div_diff;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]  quot_fix, rem_fix, a_orig;
  logic [W-1:0]  hi_res, lo_res;

  assign dbg_state = state;

  // ---------------- state register ----------------
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_RUN;
      S_RUN:   if (cnt == CW'(W-1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- output / control logic ----------------
  always_comb begin
    launch    = (state == S_IDLE) && Start;
    last_iter = (state == S_RUN) && (cnt == CW'(W-1));
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state == S_FIX);
  end

  // ---------------- datapath combinational ----------------
  always_comb begin
    // absolute values only for signed ops
    srca_abs = (Op[0] && SrcA[W-1]) ? (~SrcA + 1'b1) : SrcA;
    srcb_abs = (Op[0] && SrcB[W-1]) ? (~SrcB + 1'b1) : SrcB;

    // shift-add: add multiplicand when the current multiplier LSB is set
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_abs} : {(W+1){1'b0}});

    // restoring division: the difference is only kept when it is non-negative,
    // in which case it is < divisor and fits in W bits
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = (div_shift >= {1'b0, b_abs});
    div_diff  = div_shift[W-1:0] - b_abs;

    prod     = {acc_hi, acc_lo};
    prod_fix = (op_q[0] && (a_neg ^ b_neg)) ? (~prod + 1'b1) : prod;
    quot_fix = (op_q[0] && (a_neg ^ b_neg)) ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix  = (op_q[0] && a_neg) ? (~acc_hi + 1'b1) : acc_hi;
    // a_neg is only ever set for signed ops, so this recovers SrcA as given
    a_orig   = a_neg ? (~a_abs + 1'b1) : a_abs;

    hi_res = prod_fix[2*W-1:W];
    lo_res = prod_fix[W-1:0];
    if (op_q[1]) begin
      if (b_abs == '0) begin
        hi_res = a_orig;
        lo_res = '1;
      end else begin
        hi_res = rem_fix;
        lo_res = quot_fix;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      op_q   <= 2'b00;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      a_abs  <= '0;
      b_abs  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (launch) begin
      cnt    <= '0;
      op_q   <= Op;
      a_neg  <= Op[0] & SrcA[W-1];
      b_neg  <= Op[0] & SrcB[W-1];
      a_abs  <= srca_abs;
      b_abs  <= srcb_abs;
      acc_hi <= '0;
      acc_lo <= Op[1] ? srca_abs : srcb_abs;
    end else if (state == S_RUN) begin
      cnt <= last_iter ? '0 : cnt + CW'(1);
      if (op_q[1]) begin
        acc_hi <= div_ge ? div_diff : div_shift[W-1:0];
        acc_lo <= {acc_lo[W-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[W:1];
        acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
      end
    end
  end

  // ---------------- handshake outputs ----------------
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Busy <= busy_nxt;
      Done <= done_nxt;
    end
  end

  // ---------------- HI/LO ----------------
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      HI <= '0;
      LO <= '0;
    end else if (state == S_FIX) begin
      HI <= hi_res;
      LO <= lo_res;
    end else if (state == S_IDLE) begin
      if (HiWEn) HI <= WD;
      if (LoWEn) LO <= WD;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB, WD;
  logic        HiWEn, LoWEn;
  logic        Busy, Done;
  logic [31:0] HI, LO;
  logic [1:0]  dbg_state;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .CLK(CLK), .rst(rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiWEn(HiWEn), .LoWEn(LoWEn), .WD(WD), .Busy(Busy), .Done(Done),
    .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m, lo_m;   // bench's view of the architectural HI/LO

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition of each op.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    case (op)
      2'b00: return {32'b0, a} * {32'b0, b};
      2'b01: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        return {32'(ia % ib), 32'(ia / ib)};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // inject_at > 0: at that cycle of the run, re-pulse Start with other operands
  // and attempt MTHI/MTLO writes; all must be ignored.
  // mt_hi: assert HiWEn together with Start.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inject_at, input bit mt_hi);
    int          cycles, busy_cycles;
    logic [63:0] exp;
    @(negedge CLK);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    if (mt_hi) begin HiWEn = 1'b1; WD = 32'h5A5A_5A5A; end
    exp_q.push_back(ref_model(op, a, b));
    @(negedge CLK);
    Start = 1'b0; HiWEn = 1'b0;
    if (mt_hi) hi_m = 32'h5A5A_5A5A;
    check({tag, "_busy_start"}, Busy, 1);
    check({tag, "_hi_hold"}, HI, hi_m);
    cycles = 1; busy_cycles = 1;
    while (!Done && cycles < 100) begin
      if (cycles == inject_at) begin
        Start = 1'b1; SrcA = ~a; SrcB = b + 1; Op = ~op;
        HiWEn = 1'b1; LoWEn = 1'b1; WD = 32'h1234;
      end
      @(negedge CLK);
      Start = 1'b0; HiWEn = 1'b0; LoWEn = 1'b0;
      cycles++;
      if (Busy) busy_cycles++;
      if (inject_at > 0 && cycles == inject_at + 1) begin
        check({tag, "_hi_busy_write"}, HI, hi_m);
        check({tag, "_lo_busy_write"}, LO, lo_m);
      end
    end
    check({tag, "_latency"}, cycles, 34);
    check({tag, "_busy_cycles"}, busy_cycles, 33);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check({tag, "_result"}, {HI, LO}, exp);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    @(negedge CLK);
    check({tag, "_done_pulse"}, Done, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t1, t2, k;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b0; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
    HiWEn = 1'b0; LoWEn = 1'b0; WD = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    @(negedge CLK);

    // MT writes in IDLE
    LoWEn = 1'b1; WD = 32'hABCD;
    @(negedge CLK);
    LoWEn = 1'b0; lo_m = 32'hABCD;
    check("mtlo_lo", LO, lo_m);
    check("mtlo_hi", HI, hi_m);
    HiWEn = 1'b1; WD = 32'h1111_2222;
    @(negedge CLK);
    HiWEn = 1'b0; hi_m = 32'h1111_2222;
    check("mthi_hi", HI, hi_m);

    // directed
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'h2, 0, 0);
    check("multu_max_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
    run_op("mult_neg", 2'b01, -32'sd7, 32'd3, 0, 1);
    check("mult_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", 2'b11, -32'sd7, 32'd2, 0, 0);
    check("div_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0, 0, 0);
    check("divu_zero_const", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
    run_op("div_zero", 2'b11, 32'hFFFF_FFF0, 32'd0, 0, 0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op("start_busy", 2'b00, 32'h0001_2345, 32'h0000_0F0F, 5, 0);

    // reset mid-operation
    @(negedge CLK);
    Start = 1'b1; Op = 2'b00; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    rst = 1'b0;
    #1;
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_hi", HI, 0);
    check("midrst_lo", LO, 0);
    @(negedge CLK);
    rst = 1'b1; hi_m = '0; lo_m = '0;
    repeat (2) @(negedge CLK);
    check("midrst_no_done", Done, 0);
    run_op("after_rst", 2'b00, 32'd6, 32'd7, 0, 0);
    check("after_rst_const", {HI, LO}, 64'd42);

    // back-to-back with Start held high
    @(negedge CLK);
    Start = 1'b1; Op = 2'b10; SrcA = 32'd50; SrcB = 32'd7;
    k = 0;
    while (!Done && k < 100) begin @(negedge CLK); k++; end
    t1 = cyc;
    check("b2b_first", {HI, LO}, ref_model(2'b10, 32'd50, 32'd7));
    check("b2b_first_const", {HI, LO}, {32'd1, 32'd7});
    SrcA = 32'd9; SrcB = 32'd3;
    @(negedge CLK);
    k = 0;
    while (!Done && k < 100) begin @(negedge CLK); k++; end
    t2 = cyc;
    Start = 1'b0;
    check("b2b_gap", t2 - t1, 34);
    check("b2b_second", {HI, LO}, {32'd0, 32'd3});
    hi_m = HI; lo_m = LO;
    hi_m = 32'd0; lo_m = 32'd3;
    @(negedge CLK);

    // randomized
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
      run_op($sformatf("rand%0d", i), rop, ra, rb, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
